fifo_rr_scheduler: RTL and testbench

//  Shares one output channel between N_SRC requesters, each buffered by a private sync_fifo instance.

---
 rtl/fifo_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/fifo_rr_scheduler.sv | 176 +++++++++++++++++
 tb/tb_fifo_rr_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the round-robin FIFO scheduler.
package fifo_sched_pkg;

    localparam int N_SRC_DEF  = 4;
    localparam int STAT_WIDTH = 32;

    typedef logic [$clog2(N_SRC_DEF)-1:0] src_id_t;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        SERVE = 1'b1
    } sched_state_t;

    // Index width that stays legal for the degenerate single-source case.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first requester after i_last_grant wins.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = id_width(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic [ID_W-1:0]  o_grant,
    output logic             o_grant_any
);

    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + (ID_W + 1)'(off);
        if (sum >= (ID_W + 1)'(N_SRC)) begin
            sum = sum - (ID_W + 1)'(N_SRC);
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    // Scan from lowest to highest priority so the nearest requester after last_grant overrides.
    always_comb begin
        o_grant     = '0;
        o_grant_any = 1'b0;
        for (int off = N_SRC; off >= 1; off--) begin
            o_grant     = i_req[rot_idx(i_last_grant, off)] ? rot_idx(i_last_grant, off) : o_grant;
            o_grant_any = o_grant_any | i_req[rot_idx(i_last_grant, off)];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy counter, synchronous flush and almost-empty flag.
module sync_fifo #(
    parameter int WIDTH                  = 64,
    parameter int DEPTH                  = 4,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full         = (r_count == CW'(DEPTH));
    assign o_empty        = (r_count == '0);
    assign o_almost_empty = (r_count <= CW'(ALMOST_EMPTY_THRESHOLD));
    assign o_rd_data      = r_mem[r_rptr];
    assign w_wr           = i_wr_en && !o_full;
    assign w_rd           = i_rd_en && !o_empty;

    // Storage, pointers and occupancy; flush wins over any same-cycle access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= i_wr_data;
                r_wptr        <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// N_SRC buffered requesters sharing one valid/ready channel, round-robin with bounded bursts.
// Optional per-source beat counters on stat_beats when FIFO_SCHED_STATS_EN is defined.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_en,
    input  logic [N_SRC-1:0]             src_valid,
    input  logic [N_SRC*WIDTH-1:0]       src_data,
    output logic [N_SRC-1:0]             src_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [id_width(N_SRC)-1:0]   out_src,
    input  logic                         out_ready
`ifdef FIFO_SCHED_STATS_EN
    ,
    output logic [N_SRC*STAT_WIDTH-1:0]  stat_beats
`endif
);

    localparam int ID_W = id_width(N_SRC);
    localparam int BW   = $clog2(BURST_LEN + 1);

    sched_state_t     r_state;
    sched_state_t     w_next_state;
    logic [ID_W-1:0]  r_grant;
    logic [ID_W-1:0]  w_next_grant;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  w_next_last;
    logic [BW-1:0]    r_burst_cnt;
    logic [BW-1:0]    w_next_burst;

    logic [N_SRC-1:0] w_full;
    logic [N_SRC-1:0] w_empty;
    logic [N_SRC-1:0] w_aempty;
    logic [N_SRC-1:0] w_wr_en;
    logic [N_SRC-1:0] w_rd_en;
    logic [N_SRC-1:0] w_req;
    logic [WIDTH-1:0] w_head [N_SRC];
    logic [ID_W-1:0]  w_arb_grant;
    logic             w_arb_any;
    logic             w_beat;

    assign w_wr_en   = src_valid & ~w_full;
    assign w_req     = ~w_empty;
    assign src_ready = ~w_full;
    assign out_valid = (r_state == SERVE) && !w_empty[r_grant];
    assign out_data  = w_head[r_grant];
    assign out_src   = r_grant;
    assign w_beat    = out_valid && out_ready && !flush_en;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign w_rd_en[g] = w_beat && (r_grant == ID_W'(g));

        sync_fifo #(
            .WIDTH                  (WIDTH),
            .DEPTH                  (DEPTH),
            .ALMOST_EMPTY_THRESHOLD (1)
        ) u_fifo (
            .clk            (clk),
            .reset          (reset),
            .i_flush        (flush_en),
            .i_wr_en        (w_wr_en[g]),
            .i_wr_data      (src_data[g*WIDTH +: WIDTH]),
            .i_rd_en        (w_rd_en[g]),
            .o_rd_data      (w_head[g]),
            .o_full         (w_full[g]),
            .o_empty        (w_empty[g]),
            .o_almost_empty (w_aempty[g])
        );
    end

    rr_arbiter #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_grant_any  (w_arb_any)
    );

    // Scheduler state register; last_grant parks at N_SRC-1 so source 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ARB;
            r_grant      <= '0;
            r_last_grant <= ID_W'(N_SRC - 1);
            r_burst_cnt  <= '0;
        end else if (flush_en) begin
            r_state      <= ARB;
            r_grant      <= '0;
            r_last_grant <= ID_W'(N_SRC - 1);
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_grant <= w_next_last;
            r_burst_cnt  <= w_next_burst;
        end
    end

    // Next-state: a grant ends on burst limit, on draining the last entry, or if the FIFO is empty.
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_last  = r_last_grant;
        w_next_burst = r_burst_cnt;
        case (r_state)
            ARB: begin
                if (w_arb_any) begin
                    w_next_state = SERVE;
                    w_next_grant = w_arb_grant;
                    w_next_last  = w_arb_grant;
                    w_next_burst = '0;
                end else begin
                    w_next_state = ARB;
                end
            end
            SERVE: begin
                if (w_empty[r_grant]) begin
                    w_next_state = ARB;
                    w_next_burst = '0;
                end else if (w_beat) begin
                    if ((r_burst_cnt == BW'(BURST_LEN - 1)) ||
                        (w_aempty[r_grant] && !w_wr_en[r_grant])) begin
                        w_next_state = ARB;
                        w_next_burst = '0;
                    end else begin
                        w_next_burst = r_burst_cnt + BW'(1);
                    end
                end else begin
                    w_next_state = SERVE;
                end
            end
            default: begin
                w_next_state = ARB;
                w_next_burst = '0;
            end
        endcase
    end

`ifdef FIFO_SCHED_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat [N_SRC];

    // Saturating per-source beat counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_stat[i] <= '0;
            end
        end else if (flush_en) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_stat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_beat && (r_grant == ID_W'(i)) && (r_stat[i] != '1)) begin
                    r_stat[i] <= r_stat[i] + STAT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_stat
        assign stat_beats[g*STAT_WIDTH +: STAT_WIDTH] = r_stat[g];
    end
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed scoreboard bench for fifo_rr_scheduler (N_SRC=4, WIDTH=64, DEPTH=4, BURST_LEN=4).
module tb_fifo_rr_scheduler;

    localparam int N = 4;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_en;
    logic [N-1:0]     src_valid;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     src_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_src;
    logic             out_ready;
`ifdef FIFO_SCHED_STATS_EN
    logic [N*32-1:0]  stat_beats;
`endif

    fifo_rr_scheduler #(.N_SRC(4), .WIDTH(64), .DEPTH(4), .BURST_LEN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_en  (flush_en),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef FIFO_SCHED_STATS_EN
        ,
        .stat_beats(stat_beats)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  src;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int          beat_cyc[$];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        hold_pend = 1'b0;
    logic [1:0]  hold_src;
    logic [63:0] hold_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_src", {62'd0, out_src}, {62'd0, hold_src});
                check("hold_data", out_data, hold_data);
            end
            hold_pend = out_valid && !out_ready && !flush_en;
            hold_src  = out_src;
            hold_data = out_data;
            if (out_valid && out_ready && !flush_en) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got src %0d data %0h expected none", out_src, out_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_src", {62'd0, out_src}, {62'd0, e.src});
                    check("beat_data", out_data, e.data);
                    beat_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [63:0] d);
        src_valid[s]       = 1'b1;
        src_data[s*W +: W] = d;
    endtask

    task automatic clr();
        src_valid = '0;
    endtask

    task automatic expect_beat(input logic [1:0] s, input logic [63:0] d);
        exp_t e;
        e.src  = s;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget && !out_valid; i++) tick();
        check(name, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        check(name, sb.size(), 64'd0);
        tick();
        tick();
    endtask

    task automatic do_flush();
        flush_en = 1'b1;
        tick();
        flush_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int span;
        reset     = 1'b1;
        flush_en  = 1'b0;
        src_valid = '0;
        src_data  = '0;
        out_ready = 1'b0;
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_src", {62'd0, out_src}, 64'd0);
        check("rst_src_ready", {60'd0, src_ready}, 64'hF);
        tick();
        reset = 1'b0;
        tick();

        // 1: single enqueue on src2, two-cycle latency
        out_ready = 1'b1;
        drive(2, 64'hA0);
        expect_beat(2'd2, 64'hA0);
        tick();
        clr();
        check("lat_t1_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("lat_t2_valid", {63'd0, out_valid}, 64'd1);
        check("lat_t2_src", {62'd0, out_src}, 64'd2);
        check("lat_t2_data", out_data, 64'hA0);
        check("t1_src_ready", {60'd0, src_ready}, 64'hF);
        wait_drain("t1_drain", 10);
        do_flush();

        // 2: all FIFOs full, strict rotation with one bubble between grants
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 4; s++) drive(s, 64'h200 + 64'(s * 16 + b));
            tick();
        end
        clr();
        check("t2_all_full", {60'd0, src_ready}, 64'h0);
        for (int s = 0; s < 4; s++) drive(s, 64'hBAD);
        tick();
        clr();
        for (int s = 0; s < 4; s++)
            for (int b = 0; b < 4; b++) expect_beat(2'(s), 64'h200 + 64'(s * 16 + b));
        beat_cyc.delete();
        out_ready = 1'b1;
        wait_drain("t2_drain", 60);
        span = (beat_cyc.size() > 0) ? beat_cyc[$] - beat_cyc[0] : -1;
        check("t2_beats", beat_cyc.size(), 64'd16);
        check("t2_span", 64'(span), 64'd18);

        // 3: src0 six beats (two refilled mid-burst), src1 one beat
        out_ready = 1'b0;
        drive(0, 64'h300);
        drive(1, 64'h310);
        tick();
        clr();
        for (int b = 1; b < 4; b++) begin
            drive(0, 64'h300 + 64'(b));
            tick();
        end
        clr();
        for (int b = 0; b < 4; b++) expect_beat(2'd0, 64'h300 + 64'(b));
        expect_beat(2'd1, 64'h310);
        expect_beat(2'd0, 64'h304);
        expect_beat(2'd0, 64'h305);
        out_ready = 1'b1;
        tick();
        drive(0, 64'h304);
        tick();
        drive(0, 64'h305);
        tick();
        clr();
        wait_drain("t3_drain", 40);

        // 4: stall three cycles during SERVE with src1 full
        out_ready = 1'b0;
        drive(1, 64'h400);
        drive(3, 64'h430);
        tick();
        clr();
        for (int b = 1; b < 4; b++) begin
            drive(1, 64'h400 + 64'(b));
            tick();
        end
        clr();
        wait_valid("t4_valid", 10);
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_src", {62'd0, out_src}, 64'd1);
            check("t4_stall_data", out_data, 64'h400);
            check("t4_src_ready", {60'd0, src_ready}, 64'hD);
            tick();
        end
        for (int b = 0; b < 4; b++) expect_beat(2'd1, 64'h400 + 64'(b));
        expect_beat(2'd3, 64'h430);
        out_ready = 1'b1;
        wait_drain("t4_drain", 30);

        // 5: flush mid-burst with a same-cycle enqueue on src1
        out_ready = 1'b0;
        drive(2, 64'h500);
        drive(3, 64'h530);
        tick();
        clr();
        for (int b = 1; b < 4; b++) begin
            drive(2, 64'h500 + 64'(b));
            tick();
        end
        clr();
        wait_valid("t5_valid", 10);
        check("t5_src", {62'd0, out_src}, 64'd2);
        expect_beat(2'd2, 64'h500);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush_en  = 1'b1;
        drive(1, 64'hDEAD);
        tick();
        flush_en = 1'b0;
        clr();
        check("t5_flush_valid", {63'd0, out_valid}, 64'd0);
        check("t5_flush_ready", {60'd0, src_ready}, 64'hF);
        tick();
        tick();
        check("t5_flush_empty", {63'd0, out_valid}, 64'd0);
        expect_beat(2'd0, 64'h5A0);
        expect_beat(2'd3, 64'h5A3);
        drive(0, 64'h5A0);
        drive(3, 64'h5A3);
        tick();
        clr();
        out_ready = 1'b1;
        wait_drain("t5_drain", 30);

`ifdef FIFO_SCHED_STATS_EN
        // 6: beat counters
        do_flush();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            drive(3, 64'h600 + 64'(b));
            expect_beat(2'd3, 64'h600 + 64'(b));
            tick();
        end
        clr();
        tick();
        drive(3, 64'h604);
        expect_beat(2'd3, 64'h604);
        tick();
        clr();
        wait_drain("t6_drain", 30);
        check("t6_stat3", {32'd0, stat_beats[3*32 +: 32]}, 64'd5);
        check("t6_stat0", {32'd0, stat_beats[0 +: 32]}, 64'd0);
        do_flush();
        check("t6_stat3_flush", {32'd0, stat_beats[3*32 +: 32]}, 64'd0);
`endif

        // Asynchronous reset while a beat is presented
        out_ready = 1'b0;
        drive(1, 64'h700);
        tick();
        clr();
        wait_valid("rst_mid_valid", 10);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_out_src", {62'd0, out_src}, 64'd0);
        check("rst_mid_src_ready", {60'd0, src_ready}, 64'hF);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("final_sb_empty", sb.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
